// File: rtl/ns_gnrl_burst_rr_arb.sv
// rtl/ns_gnrl_burst_rr_arb.sv - round-robin burst-locking arbiter with burst-length watchdog
module ns_gnrl_burst_rr_arb #(
  parameter int REQ_NUM   = 4,
  parameter int DW        = 32,
  parameter int MAX_BEATS = 16,
  localparam int ID_W     = $clog2(REQ_NUM),
  localparam int CNT_W    = $clog2(MAX_BEATS + 1)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [REQ_NUM-1:0]    req_valid,
  input  logic [REQ_NUM-1:0]    req_last,
  input  logic [REQ_NUM*DW-1:0] req_data,
  output logic [REQ_NUM-1:0]    req_ready,
  output logic                  out_valid,
  output logic [DW-1:0]         out_data,
  output logic                  out_last,
  output logic [ID_W-1:0]       out_id,
  input  logic                  out_ready,
  output logic                  busy,
  output logic                  burst_err,
  input  logic                  burst_err_clr
);

  typedef enum logic {
    S_IDLE  = 1'b0,
    S_BURST = 1'b1
  } state_t;

  state_t           state, nxt_state;
  logic [ID_W-1:0]  gid, nxt_gid;
  logic [ID_W-1:0]  ptr, nxt_ptr;
  logic [CNT_W-1:0] beat_cnt, nxt_cnt;
  logic             set_err;
  logic             beat;
  logic             found;
  logic [ID_W-1:0]  sel;
  int               idx;

  // Rotating-priority search: first valid requester starting at ptr, wrapping around.
  always_comb begin
    found = 1'b0;
    sel   = '0;
    idx   = 0;
    for (int k = 0; k < REQ_NUM; k++) begin
      idx = int'(ptr) + k;
      if (idx >= REQ_NUM) idx = idx - REQ_NUM;
      if (!found && req_valid[ID_W'(idx)]) begin
        found = 1'b1;
        sel   = ID_W'(idx);
      end
    end
  end

  // Next-state logic and the pass-through channel while a burst holds the grant.
  always_comb begin
    nxt_state = state;
    nxt_gid   = gid;
    nxt_ptr   = ptr;
    nxt_cnt   = beat_cnt;
    set_err   = 1'b0;
    beat      = 1'b0;
    req_ready = '0;
    out_valid = 1'b0;
    out_last  = 1'b0;
    out_id    = '0;
    busy      = 1'b0;
    out_data  = req_data[int'(gid)*DW +: DW];
    case (state)
      S_IDLE: begin
        if (found) begin
          nxt_gid   = sel;
          nxt_state = S_BURST;
        end
      end
      S_BURST: begin
        busy           = 1'b1;
        out_id         = gid;
        out_valid      = req_valid[gid];
        out_last       = req_last[gid];
        req_ready[gid] = out_ready;
        beat           = out_valid & out_ready;
        if (beat) begin
          if (out_last) begin
            nxt_state = S_IDLE;
            nxt_cnt   = '0;
            nxt_ptr   = (int'(gid) == REQ_NUM - 1) ? '0 : gid + 1'b1;
          end else begin
            // The MAX_BEATS-th beat not being last means the burst is overlong.
            if (beat_cnt == CNT_W'(MAX_BEATS - 1)) set_err = 1'b1;
            if (beat_cnt != CNT_W'(MAX_BEATS)) nxt_cnt = beat_cnt + 1'b1;
          end
        end
      end
      default: nxt_state = S_IDLE;
    endcase
  end

  // State registers; a watchdog set outranks a simultaneous clear.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      gid       <= '0;
      ptr       <= '0;
      beat_cnt  <= '0;
      burst_err <= 1'b0;
    end else begin
      state    <= nxt_state;
      gid      <= nxt_gid;
      ptr      <= nxt_ptr;
      beat_cnt <= nxt_cnt;
      if (set_err)            burst_err <= 1'b1;
      else if (burst_err_clr) burst_err <= 1'b0;
    end
  end

endmodule

// File: tb/tb_ns_gnrl_burst_rr_arb.sv
// tb/tb_ns_gnrl_burst_rr_arb.sv - self-checking bench for ns_gnrl_burst_rr_arb
module tb_ns_gnrl_burst_rr_arb;

  localparam int N    = 4;
  localparam int DW   = 32;
  localparam int MAXB = 16;
  localparam int IW   = $clog2(N);

  logic            clk;
  logic            rst_n;
  logic [N-1:0]    req_valid;
  logic [N-1:0]    req_last;
  logic [N*DW-1:0] req_data;
  logic [N-1:0]    req_ready;
  logic            out_valid;
  logic [DW-1:0]   out_data;
  logic            out_last;
  logic [IW-1:0]   out_id;
  logic            out_ready;
  logic            busy;
  logic            burst_err;
  logic            burst_err_clr;

  ns_gnrl_burst_rr_arb #(.REQ_NUM(N), .DW(DW), .MAX_BEATS(MAXB)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_last(req_last),
    .req_data(req_data), .req_ready(req_ready), .out_valid(out_valid),
    .out_data(out_data), .out_last(out_last), .out_id(out_id),
    .out_ready(out_ready), .busy(busy), .burst_err(burst_err),
    .burst_err_clr(burst_err_clr)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int tests = 0;
  int fails = 0;
  int cyc   = 0;

  // reference model: who owns the channel, who is next in line, beats so far
  bit m_known = 1'b0;
  bit m_busy;
  int m_owner;
  int m_next;
  int m_beats;
  bit m_err;
  int log_id[$];
  int log_cyc[$];

  // requester generator
  bit manual   = 1'b1;
  bit rand_ctl = 1'b0;
  logic [N-1:0] gen_mask = '0;
  int gen_lo = 2, gen_hi = 2, gen_vpct = 100, gen_spct = 100;
  int rem[N];
  int seq[N];

  // samples taken at the falling edge
  logic            s_busy, s_out_valid, s_out_last, s_burst_err, s_hs;
  logic [IW-1:0]   s_out_id;
  logic [DW-1:0]   s_out_data;
  logic [N-1:0]    s_req_ready;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_model();
    logic [N-1:0] er;
    logic         ev;
    er = '0;
    ev = m_busy && req_valid[m_owner];
    if (m_busy && out_ready) er[m_owner] = 1'b1;
    chk("busy", busy, m_busy);
    chk("out_valid", out_valid, ev);
    chk("req_ready", req_ready, er);
    chk("burst_err", burst_err, m_err);
    if (m_busy) begin
      chk("out_id", out_id, m_owner);
      chk("out_last", out_last, req_last[m_owner]);
    end
    if (ev) chk("out_data", out_data, req_data[m_owner*DW +: DW]);
  endtask

  task automatic update_model();
    bit set;
    set = 1'b0;
    if (!rst_n) begin
      m_known = 1'b1; m_busy = 1'b0; m_owner = 0; m_next = 0; m_beats = 0; m_err = 1'b0;
    end else if (m_known) begin
      if (!m_busy) begin
        if (req_valid != '0) begin
          for (int k = N - 1; k >= 0; k--)
            if (req_valid[(m_next + k) % N]) m_owner = (m_next + k) % N;
          m_busy = 1'b1;
          log_id.push_back(m_owner);
          log_cyc.push_back(cyc);
        end
      end else if (req_valid[m_owner] && out_ready) begin
        m_beats++;
        if (req_last[m_owner]) begin
          m_busy = 1'b0; m_next = (m_owner + 1) % N; m_beats = 0;
        end else if (m_beats == MAXB) begin
          set = 1'b1;
        end
      end
      if (set) m_err = 1'b1;
      else if (burst_err_clr) m_err = 1'b0;
    end
  endtask

  task automatic drive_gen();
    for (int i = 0; i < N; i++) begin
      if (rem[i] == 0 && gen_mask[i] && ($urandom % 100) < gen_spct)
        rem[i] = (gen_lo == gen_hi) ? gen_lo :
                 (($urandom % 8) == 0 ? $urandom_range(15, 20) : $urandom_range(gen_lo, gen_hi));
      req_valid[i] = (rem[i] > 0) && (($urandom % 100) < gen_vpct);
      req_last[i]  = (rem[i] == 1);
      req_data[i*DW +: DW] = {8'(i), seq[i][23:0]};
    end
    if (rand_ctl) begin
      out_ready     = ($urandom % 100) < 75;
      burst_err_clr = ($urandom % 100) < 5;
      rst_n         = ($urandom % 500) != 0;
    end
  endtask

  task automatic step();
    logic [N-1:0] hs_vec;
    @(negedge clk);
    cyc++;
    s_busy = busy; s_out_valid = out_valid; s_out_last = out_last; s_out_id = out_id;
    s_out_data = out_data; s_req_ready = req_ready; s_burst_err = burst_err;
    s_hs = out_valid & out_ready;
    if (m_known) check_model();
    hs_vec = req_valid & req_ready;
    if (!manual)
      for (int i = 0; i < N; i++)
        if (hs_vec[i] && rem[i] > 0) begin rem[i]--; seq[i]++; end
    update_model();
    @(posedge clk);
    #1;
    if (!manual) drive_gen();
  endtask

  task automatic drain();
    int guard;
    int left;
    guard = 0;
    gen_mask = '0;
    left = 1;
    while (left != 0 && guard < 600) begin
      left = m_busy ? 1 : 0;
      for (int i = 0; i < N; i++) left += rem[i];
      if (left != 0) step();
      guard++;
    end
    chk("drain_done", left, 0);
  endtask

  task automatic run_grants(input int n, input logic [N-1:0] mask, input int len);
    int guard;
    guard = 0;
    log_id.delete(); log_cyc.delete();
    manual = 1'b0; gen_lo = len; gen_hi = len; gen_vpct = 100; gen_spct = 100;
    gen_mask = mask;
    while (log_id.size() < n && guard < 200) begin step(); guard++; end
    chk("grant_timeout", log_id.size() >= n, 1'b1);
    drain();
  endtask

  task automatic long_burst(input int nbeats, input bit clr);
    manual = 1'b1; out_ready = 1'b1; burst_err_clr = clr;
    req_valid = 4'b0010; req_last = '0; req_data[DW +: DW] = 32'hB000;
    step();
    for (int b = 1; b <= nbeats; b++) begin
      req_last = (b == nbeats) ? 4'b0010 : 4'b0000;
      req_data[DW +: DW] = 32'hB000 + b;
      step();
      chk("wd_beat", s_hs, 1'b1);
      chk("wd_err", s_burst_err, b > MAXB);
    end
    req_valid = '0; req_last = '0;
    step();
    chk("wd_idle", s_busy, 1'b0);
    chk("wd_sticky", s_burst_err, (nbeats > MAXB) && !clr);
  endtask

  initial begin
    logic [DW-1:0] got[$];
    int            acc;
    int            guard;
    logic [4*IW-1:0] dummy;
    dummy = '0;
    for (int i = 0; i < N; i++) begin rem[i] = 0; seq[i] = 0; end
    rst_n = 1'b0; req_valid = '0; req_last = '0; req_data = '0;
    out_ready = 1'b1; burst_err_clr = 1'b0;
    #1;
    step();
    step();
    chk("rst_busy", s_busy, 1'b0);
    chk("rst_ready", s_req_ready, 4'b0);
    chk("rst_valid", s_out_valid, 1'b0);
    chk("rst_id", s_out_id, 2'd0);
    chk("rst_last", s_out_last, 1'b0);
    chk("rst_err", s_burst_err, 1'b0);
    rst_n = 1'b1;

    // quiet bus
    repeat (5) begin
      step();
      chk("idle_busy", s_busy, 1'b0);
      chk("idle_ready", s_req_ready, 4'b0);
      chk("idle_valid", s_out_valid, 1'b0);
    end

    // everyone requesting, two-beat bursts
    run_grants(5, 4'b1111, 2);
    for (int k = 0; k < 5; k++) chk("rr_order", log_id[k], (k % N));
    for (int k = 0; k < 4; k++) chk("rr_spacing", log_cyc[k+1] - log_cyc[k], 3);

    // priority pointer wraps from 3 to 0
    run_grants(1, 4'b0100, 2);
    chk("wrap_prime", log_id[0], 2);
    run_grants(2, 4'b1001, 2);
    chk("wrap_first", log_id[0], 3);
    chk("wrap_second", log_id[1], 0);

    // owner stalls mid-burst while another requester waits
    manual = 1'b1; out_ready = 1'b1;
    req_valid = 4'b0001; req_last = '0; req_data[0 +: DW] = 32'hD0; req_data[DW +: DW] = 32'h11;
    step();
    step();
    chk("stall_beat1", s_hs, 1'b1);
    req_valid = 4'b0010;
    repeat (3) begin
      step();
      chk("stall_valid", s_out_valid, 1'b0);
      chk("stall_id", s_out_id, 2'd0);
      chk("stall_rdy1", s_req_ready[1], 1'b0);
    end
    req_valid = 4'b0011; req_last = 4'b0001;
    step();
    chk("stall_end", s_hs & s_out_last, 1'b1);
    req_valid = 4'b0010; req_last = 4'b0010;
    step();
    step();
    chk("single_id", s_out_id, 2'd1);
    chk("single_beat", s_hs & s_out_last, 1'b1);
    req_valid = '0; req_last = '0;
    step();
    chk("single_done", s_busy, 1'b0);

    // downstream ready toggling during a four-beat burst
    req_valid = 4'b0100; req_data[2*DW +: DW] = 32'hA0;
    step();
    acc = 0; guard = 0;
    while (acc < 4 && guard < 20) begin
      out_ready = (guard % 2) == 0;
      req_data[2*DW +: DW] = 32'hA0 + acc;
      req_last = (acc == 3) ? 4'b0100 : 4'b0000;
      step();
      if (s_hs) begin
        got.push_back(s_out_data);
        chk("tog_last", s_out_last, acc == 3);
        acc++;
      end
      guard++;
    end
    chk("tog_count", got.size(), 4);
    for (int k = 0; k < 4 && k < got.size(); k++) chk("tog_data", got[k], 32'hA0 + k);
    req_valid = '0; req_last = '0; out_ready = 1'b1;
    step();

    // watchdog: exact-length burst is fine, one more beat flags it
    long_burst(16, 1'b0);
    long_burst(17, 1'b0);
    burst_err_clr = 1'b1;
    step();
    chk("clr_pending", s_burst_err, 1'b1);
    burst_err_clr = 1'b0;
    step();
    chk("clr_done", s_burst_err, 1'b0);
    long_burst(17, 1'b1);
    burst_err_clr = 1'b0;

    // reset in the middle of a burst
    req_valid = 4'b1000; req_last = '0; req_data[3*DW +: DW] = 32'hC3;
    step(); step(); step();
    chk("mid_busy", s_busy, 1'b1);
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    step();
    chk("abort_busy", s_busy, 1'b0);
    chk("abort_ready", s_req_ready, 4'b0);
    chk("abort_valid", s_out_valid, 1'b0);
    req_last = 4'b1000;
    step();
    chk("restart_id", s_out_id, 2'd3);
    req_valid = '0; req_last = '0;
    step();

    // randomized traffic against the model
    manual = 1'b0; rand_ctl = 1'b1; gen_lo = 1; gen_hi = 6; gen_vpct = 70; gen_spct = 30;
    gen_mask = 4'b1111;
    repeat (3000) step();
    rand_ctl = 1'b0; rst_n = 1'b1; out_ready = 1'b1; burst_err_clr = 1'b0;
    drain();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
